// File: rtl/branch_pc_unit_if.sv
// Bus between decode/ALU and the branch/PC unit: per-instruction controls and ALU flags in,
// PC state plus branch resolution and link write-back out.
interface branch_pc_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                instr_valid;
    logic                stall;
    logic [3:0]          br_op;
    logic                flag_we;
    logic                alu_carry;
    logic                alu_zero;
    logic                alu_sign;
    logic [31:0]         alu_result;
    logic [PC_WIDTH-1:0] imm_target;
    logic [PC_WIDTH-1:0] pc;
    logic                taken;
    logic                flush;
    logic                carry_flag;
    logic                link_we;
    logic [PC_WIDTH-1:0] link_data;

    modport master (
        output instr_valid, stall, br_op, flag_we, alu_carry, alu_zero, alu_sign,
               alu_result, imm_target,
        input  pc, taken, flush, carry_flag, link_we, link_data
    );

    modport slave (
        input  instr_valid, stall, br_op, flag_we, alu_carry, alu_zero, alu_sign,
               alu_result, imm_target,
        output pc, taken, flush, carry_flag, link_we, link_data
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution, PC and carry-flag owner; taken/link are same-cycle, PC/flag/flush update next edge.
// Stall or invalid instruction holds all state and clears flush; no other backpressure.
module branch_pc_unit #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 4
) (
    input logic             clk,
    input logic             rst,
    branch_pc_unit_if.slave bus
);
    localparam logic [3:0] BR_NONE = 4'b0000;
    localparam logic [3:0] BR_B    = 4'b0001;
    localparam logic [3:0] BR_R    = 4'b0010;
    localparam logic [3:0] BR_L    = 4'b0011;
    localparam logic [3:0] BR_CY   = 4'b0100;
    localparam logic [3:0] BR_NCY  = 4'b0101;
    localparam logic [3:0] BR_Z    = 4'b0110;
    localparam logic [3:0] BR_NZ   = 4'b0111;
    localparam logic [3:0] BR_LTZ  = 4'b1000;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_carry;
    logic                r_flush;

    logic                w_adv;
    logic                w_cond;
    logic                w_taken;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_target;

    assign w_adv    = bus.instr_valid & ~bus.stall;
    assign w_pc_inc = r_pc + PC_WIDTH'(PC_STEP);
    assign w_target = (bus.br_op == BR_R) ? bus.alu_result[PC_WIDTH-1:0] : bus.imm_target;

    // Carry branches see the registered flag, so a flag_we on the same instruction is not yet visible.
    always_comb begin
        w_cond = 1'b0;
        case (bus.br_op)
            BR_NONE: w_cond = 1'b0;
            BR_B:    w_cond = 1'b1;
            BR_R:    w_cond = 1'b1;
            BR_L:    w_cond = 1'b1;
            BR_CY:   w_cond = r_carry;
            BR_NCY:  w_cond = ~r_carry;
            BR_Z:    w_cond = bus.alu_zero;
            BR_NZ:   w_cond = ~bus.alu_zero;
            BR_LTZ:  w_cond = bus.alu_sign;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken = w_adv & w_cond;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_carry <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_taken;
            if (w_adv) begin
                r_pc <= w_taken ? w_target : w_pc_inc;
                if (bus.flag_we) begin
                    r_carry <= bus.alu_carry;
                end
            end
        end
    end

    assign bus.pc         = r_pc;
    assign bus.taken      = w_taken;
    assign bus.flush      = r_flush;
    assign bus.carry_flag = r_carry;
    assign bus.link_we    = w_adv & (bus.br_op == BR_L);
    assign bus.link_data  = w_pc_inc;
endmodule
